// File: rtl/stage_id_ex_pipe.sv
// ID->EX pipeline register: operand forwarding, operand select, load-use
// stall detection and a single-slot valid/ready output register.

// Per-source forwarding picker: youngest matching channel wins, x0 reads 0.
module stage_id_ex_fwd #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input  logic [4:0]           i_src,
  input  logic [XLEN-1:0]      i_rf,
  input  logic [NFWD-1:0]      i_fwd_valid,
  input  logic [5*NFWD-1:0]    i_fwd_rd,
  input  logic [XLEN*NFWD-1:0] i_fwd_dat,
  output logic [XLEN-1:0]      o_dat
);
  // Scan oldest to youngest so the lowest matching channel overrides.
  always_comb begin
    o_dat = i_rf;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (i_fwd_valid[k] && (i_fwd_rd[5*k +: 5] == i_src))
        o_dat = i_fwd_dat[XLEN*k +: XLEN];
    end
    if (i_src == 5'd0) o_dat = '0;
  end
endmodule

module stage_id_ex_pipe #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [1:0]           sel_dat_a_i,
  input  logic [1:0]           sel_dat_b_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [4:0]           rd_i,
  input  logic                 use_rs2_i,
  input  logic [XLEN-1:0]      rs1_d_i,
  input  logic [XLEN-1:0]      rs2_d_i,
  input  logic                 we_rd_i,
  input  logic                 is_load_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [5*NFWD-1:0]    fwd_rd_i,
  input  logic [XLEN*NFWD-1:0] fwd_dat_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      dat_a_o,
  output logic [XLEN-1:0]      dat_b_o,
  output logic [XLEN-1:0]      st_dat_o,
  output logic [XLEN-1:0]      pc_o,
  output logic [4:0]           rd_o,
  output logic                 we_rd_o,
  output logic                 is_load_o,
  output logic                 hazard_o
);
  // Source 0 is rs1, source 1 is rs2.
  logic [1:0][4:0]      w_src;
  logic [1:0][XLEN-1:0] w_rf;
  logic [1:0][XLEN-1:0] w_fwd;
  logic [XLEN-1:0]      w_op_a, w_op_b;
  logic                 w_dep_a, w_dep_b, w_accept;

  logic                 r_valid, r_we, r_ld;
  logic [XLEN-1:0]      r_dat_a, r_dat_b, r_st, r_pc;
  logic [4:0]           r_rd;

  assign w_src = {rs2_i, rs1_i};
  assign w_rf  = {rs2_d_i, rs1_d_i};

  for (genvar g = 0; g < 2; g++) begin : g_src
    stage_id_ex_fwd #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd (
      .i_src       (w_src[g]),
      .i_rf        (w_rf[g]),
      .i_fwd_valid (fwd_valid_i),
      .i_fwd_rd    (fwd_rd_i),
      .i_fwd_dat   (fwd_dat_i),
      .o_dat       (w_fwd[g])
    );
  end

  function automatic logic [XLEN-1:0] opmux(input logic [1:0] sel,
                                            input logic [XLEN-1:0] r,
                                            input logic [XLEN-1:0] imm,
                                            input logic [XLEN-1:0] pc);
    case (sel)
      2'b00:   return r;
      2'b01:   return imm;
      2'b10:   return pc;
      default: return '0;
    endcase
  endfunction

  assign w_op_a = opmux(sel_dat_a_i, w_fwd[0], imm_i, pc_i);
  assign w_op_b = opmux(sel_dat_b_i, w_fwd[1], imm_i, pc_i);

  // A load in the slot cannot forward yet; stall any consumer of its rd.
  assign w_dep_a  = (sel_dat_a_i == 2'b00) && (rs1_i == r_rd);
  assign w_dep_b  = ((sel_dat_b_i == 2'b00) || use_rs2_i) && (rs2_i == r_rd);
  assign hazard_o = r_valid && r_ld && r_we && (r_rd != 5'd0) && in_valid_i &&
                    (w_dep_a || w_dep_b);

  assign in_ready_o = (!r_valid || out_ready_i) && !hazard_o;
  assign w_accept   = in_valid_i && in_ready_o && !flush_i;

  // Slot update: flush beats accept; otherwise accept, drain or hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_dat_a <= '0;
      r_dat_b <= '0;
      r_st    <= '0;
      r_pc    <= '0;
      r_rd    <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_we    <= we_rd_i;
      r_ld    <= is_load_i;
      r_dat_a <= w_op_a;
      r_dat_b <= w_op_b;
      r_st    <= w_fwd[1];
      r_pc    <= pc_i;
      r_rd    <= rd_i;
    end else if (!r_valid || out_ready_i) begin
      // Drained with nothing to take in (includes load-use bubble).
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_valid;
  assign dat_a_o     = r_dat_a;
  assign dat_b_o     = r_dat_b;
  assign st_dat_o    = r_st;
  assign pc_o        = r_pc;
  assign rd_o        = r_rd;
  assign we_rd_o     = r_we;
  assign is_load_o   = r_ld;
endmodule

// File: tb/tb_stage_id_ex_pipe.sv
// Bench for stage_id_ex_pipe: vector table plus hand sequences for stall,
// hold, flush and reset; a single-channel instance rides along the table.
module tb_stage_id_ex_pipe;
  logic        clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] pc = 0, imm = 0, rs1_d = 0, rs2_d = 0;
  logic [1:0]  sa = 0, sb = 0;
  logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
  logic        use_rs2 = 0, we = 0, ld = 0;
  logic [1:0]  fv = 0;
  logic [9:0]  frd = 0;
  logic [63:0] fdat = 0;
  logic        in_ready, out_valid, we_o, ld_o, hazard;
  logic [31:0] a_o, b_o, st_o, pc_o;
  logic [4:0]  rd_o;
  logic        in_ready1, out_valid1, we_o1, ld_o1, hazard1;
  logic [31:0] a_o1, b_o1, st_o1, pc_o1;
  logic [4:0]  rd_o1;

  always #5 clk = ~clk;

  stage_id_ex_pipe #(.XLEN(32), .NFWD(2)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .pc_i(pc), .imm_i(imm), .sel_dat_a_i(sa),
    .sel_dat_b_i(sb), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .use_rs2_i(use_rs2),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .we_rd_i(we), .is_load_i(ld),
    .fwd_valid_i(fv), .fwd_rd_i(frd), .fwd_dat_i(fdat),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .dat_a_o(a_o),
    .dat_b_o(b_o), .st_dat_o(st_o), .pc_o(pc_o), .rd_o(rd_o), .we_rd_o(we_o),
    .is_load_o(ld_o), .hazard_o(hazard));

  stage_id_ex_pipe #(.XLEN(32), .NFWD(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready1), .pc_i(pc), .imm_i(imm), .sel_dat_a_i(sa),
    .sel_dat_b_i(sb), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .use_rs2_i(use_rs2),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .we_rd_i(we), .is_load_i(ld),
    .fwd_valid_i(fv[0:0]), .fwd_rd_i(frd[4:0]), .fwd_dat_i(fdat[31:0]),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .dat_a_o(a_o1),
    .dat_b_o(b_o1), .st_dat_o(st_o1), .pc_o(pc_o1), .rd_o(rd_o1),
    .we_rd_o(we_o1), .is_load_o(ld_o1), .hazard_o(hazard1));

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_d, rs2_d, pc, imm;
    logic [1:0]  sa, sb, fv;
    logic [4:0]  fr0, fr1;
    logic [31:0] fd0, fd1;
    logic [31:0] ea, eb, est;
    bit          n1;   // single-channel instance expects the same a/b
  } vec_t;

  typedef struct {
    logic [31:0] a, b, st, pc;
    logic [4:0]  rd;
  } exp_t;

  vec_t vt[9];
  exp_t sb_q[$];
  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a, b, st, p, input logic [4:0] r);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.pc = p; e.rd = r;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL %s: scoreboard empty, got out_valid=%b", tag, out_valid);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".a"},   a_o,  e.a);
      chk({tag, ".b"},   b_o,  e.b);
      chk({tag, ".st"},  st_o, e.st);
      chk({tag, ".pc"},  pc_o, e.pc);
      chk({tag, ".rd"},  {27'd0, rd_o}, {27'd0, e.rd});
    end
  endtask

  task automatic instr(input logic [4:0] r1, r2, input logic [31:0] d1, d2,
                       input logic [1:0] s_a, s_b, input logic [31:0] p, im,
                       input logic [4:0] d, input logic w, l, u2);
    rs1 = r1; rs2 = r2; rs1_d = d1; rs2_d = d2; sa = s_a; sb = s_b;
    pc = p; imm = im; rd = d; we = w; ld = l; use_rs2 = u2;
    fv = 0; frd = 0; fdat = 0; in_valid = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // rs1, rs2, rs1_d, rs2_d, pc, imm, sa, sb, fv, fr0, fr1, fd0, fd1, ea, eb, est, n1
    vt[0] = '{5, 6, 10, 20, 32'h100, 4, 0, 0, 2'b00, 0, 0, 0, 0, 10, 20, 20, 1};
    vt[1] = '{5, 6, 10, 20, 32'h104, 4, 0, 0, 2'b11, 5, 5, 'hAA, 'hBB, 'hAA, 20, 20, 1};
    vt[2] = '{0, 6, 'h1234, 20, 32'h108, 4, 0, 0, 2'b11, 5, 5, 'hAA, 'hBB, 0, 20, 20, 1};
    vt[3] = '{5, 6, 10, 20, 32'h10C, 4, 0, 0, 2'b10, 5, 6, 'hAA, 'hBB, 10, 'hBB, 'hBB, 0};
    vt[4] = '{3, 4, 'hDEADBEEF, 'h12345678, 32'hC8, 'hFFFFFFF0, 1, 2, 2'b00, 0, 0, 0, 0,
              'hFFFFFFF0, 'hC8, 'h12345678, 1};
    vt[5] = '{3, 4, 'hDEADBEEF, 'h12345678, 32'hCC, 9, 3, 3, 2'b00, 0, 0, 0, 0,
              0, 0, 'h12345678, 1};
    vt[6] = '{3, 4, 1, 2, 32'h300, 7, 2, 1, 2'b01, 4, 0, 'hAA, 0, 'h300, 7, 'hAA, 1};
    vt[7] = '{9, 0, 1, 2, 32'h304, 0, 0, 0, 2'b11, 0, 9, 'hAA, 'hBB, 'hBB, 0, 0, 0};
    vt[8] = '{31, 31, 'hFFFFFFFF, 'h80000000, 32'hFFFFFFFC, 0, 0, 0, 2'b00, 0, 0, 0, 0,
              'hFFFFFFFF, 'h80000000, 'h80000000, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", {31'd0, out_valid}, 0);
    chk("rst.a", a_o, 0);
    chk("rst.st", st_o, 0);
    chk("rst.we", {31'd0, we_o}, 0);
    rst = 1;
    out_ready = 1;

    // Table: back-to-back, one result per cycle
    for (int i = 0; i < 9; i++) begin
      instr(vt[i].rs1, vt[i].rs2, vt[i].rs1_d, vt[i].rs2_d, vt[i].sa, vt[i].sb,
            vt[i].pc, vt[i].imm, 5'(i + 1), 0, 0, 0);
      fv = vt[i].fv; frd = {vt[i].fr1, vt[i].fr0}; fdat = {vt[i].fd1, vt[i].fd0};
      #1;
      chk($sformatf("v%0d.rdy", i), {31'd0, in_ready}, 1);
      push(vt[i].ea, vt[i].eb, vt[i].est, vt[i].pc, 5'(i + 1));
      tick();
      pop_chk($sformatf("v%0d", i));
      if (vt[i].n1) begin
        chk($sformatf("v%0d.n1a", i), a_o1, vt[i].ea);
        chk($sformatf("v%0d.n1b", i), b_o1, vt[i].eb);
      end
    end
    in_valid = 0;
    tick();
    chk("drain.vld", {31'd0, out_valid}, 0);

    // Load-use stall: load rd=7, consumer uses rs2=7 via use_rs2
    instr(1, 2, 11, 22, 0, 0, 32'h400, 0, 7, 1, 1, 0);
    #1; push(11, 22, 22, 32'h400, 7);
    tick();
    pop_chk("ld");
    chk("ld.isld", {31'd0, ld_o}, 1);
    instr(3, 7, 33, 77, 0, 1, 32'h404, 8, 8, 0, 0, 1);
    #1;
    chk("lu.hazard", {31'd0, hazard}, 1);
    chk("lu.rdy", {31'd0, in_ready}, 0);
    tick();
    chk("lu.bubble", {31'd0, out_valid}, 0);
    chk("lu.hz2", {31'd0, hazard}, 0);
    chk("lu.rdy2", {31'd0, in_ready}, 1);
    push(33, 8, 77, 32'h404, 8);
    tick();
    pop_chk("lu.acc");

    // Hold with out_ready low for 3 cycles
    out_ready = 0;
    instr(1, 2, 'h55, 'h66, 0, 0, 32'h500, 0, 9, 1, 1, 0);
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("hold%0d.rdy", j), {31'd0, in_ready}, 0);
      tick();
      chk($sformatf("hold%0d.vld", j), {31'd0, out_valid}, 1);
      chk($sformatf("hold%0d.a", j), a_o, 33);
      chk($sformatf("hold%0d.rd", j), {27'd0, rd_o}, 8);
    end
    out_ready = 1;
    #1;
    chk("rel.rdy", {31'd0, in_ready}, 1);
    push('h55, 'h66, 'h66, 32'h500, 9);
    tick();
    pop_chk("rel");

    // Flush with an incoming instruction while the slot holds a load
    instr(4, 5, 'h44, 'h45, 0, 0, 32'h600, 0, 10, 0, 0, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("fl.vld", {31'd0, out_valid}, 0);
    chk("fl.we", {31'd0, we_o}, 0);
    chk("fl.ld", {31'd0, ld_o}, 0);
    instr(9, 0, 'h99, 0, 0, 0, 32'h700, 0, 11, 0, 0, 0);
    #1;
    chk("fl.hz", {31'd0, hazard}, 0);
    push('h99, 0, 0, 32'h700, 11);
    tick();
    pop_chk("postfl");

    // Async reset mid-cycle while the slot holds
    out_ready = 0; in_valid = 0;
    #3; rst = 0; #1;
    chk("ar.vld", {31'd0, out_valid}, 0);
    chk("ar.a", a_o, 0);
    chk("ar.b", b_o, 0);
    chk("ar.pc", pc_o, 0);
    chk("ar.rd", {27'd0, rd_o}, 0);
    out_ready = 1;
    instr(2, 3, 'h21, 'h31, 0, 0, 32'h800, 0, 12, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    push('h21, 'h31, 'h31, 32'h800, 12);
    tick();
    pop_chk("postrst");
    in_valid = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/stage_id_ex_pipe.md
STAGE_ID_EX_PIPE -- requirements
Module: stage_id_ex_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter NFWD, default 2, number of forwarding channels; channel 0 is the youngest producer.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  discard the instruction being accepted and the one held in the output register.
REQ-006 in_valid_i  in  1 / in_ready_o  out  1  upstream handshake.
REQ-007 pc_i, imm_i  in  XLEN each  instruction PC and generated immediate.
REQ-008 sel_dat_a_i, sel_dat_b_i  in  2 each  operand select: 00 reg, 01 imm, 10 pc, 11 zero.
REQ-009 rs1_i, rs2_i, rd_i  in  5 each  register addresses.
REQ-010 use_rs2_i  in  1  rs2 is consumed even when sel_dat_b_i != 00 (stores, branches).
REQ-011 rs1_d_i, rs2_d_i  in  XLEN each  register-file read data.
REQ-012 we_rd_i, is_load_i  in  1 each  instruction writes rd / is a load.
REQ-013 fwd_valid_i  in  NFWD; fwd_rd_i  in  5*NFWD; fwd_dat_i  in  XLEN*NFWD  forwarding channels, channel k in slice k.
REQ-014 out_valid_o  out  1 / out_ready_i  in  1  downstream handshake.
REQ-015 dat_a_o, dat_b_o, st_dat_o, pc_o  out  XLEN each  registered ALU operands, forwarded rs2 data, PC.
REQ-016 rd_o  out  5; we_rd_o, is_load_o  out  1 each  registered control.
REQ-017 hazard_o  out  1  combinational load-use stall indicator.

Function
REQ-018 The block SHALL hold one output register slot with latency of exactly 1 cycle from accept to out_valid_o.
REQ-019 Accept SHALL occur when in_valid_i && in_ready_o && !flush_i.
REQ-020 in_ready_o SHALL equal (!out_valid_o || out_ready_i) && !hazard_o.
REQ-021 hazard_o SHALL be 1 when out_valid_o && is_load_o && we_rd_o && rd_o != 0 && in_valid_i, and either (sel_dat_a_i == 00 && rs1_i == rd_o) or ((sel_dat_b_i == 00 || use_rs2_i) && rs2_i == rd_o).
REQ-022 When hazard_o && out_ready_i, the slot SHALL load a bubble: out_valid_o = 0 next cycle, with the upstream instruction not accepted.
REQ-023 Forwarded rs1 data SHALL be fwd_dat_i slice k for the lowest k with fwd_valid_i[k] && fwd_rd_i[k] == rs1_i && rs1_i != 0; otherwise it SHALL be rs1_d_i. rs2 SHALL follow the same rule.
REQ-024 Any source address of 0 SHALL yield data 0 regardless of rs*_d_i and the forwarding inputs.
REQ-025 The operand mux SHALL take its reg input from forwarded rs1 (for a) or forwarded rs2 (for b); imm, pc and zero select imm_i, pc_i and 0 respectively.
REQ-026 st_dat_o SHALL capture forwarded rs2 data independent of sel_dat_b_i.
REQ-027 When out_valid_o && !out_ready_i, all outputs SHALL remain stable and in_ready_o SHALL be 0.
REQ-028 When the slot empties with no accept (out_ready_i && !accept), out_valid_o SHALL go to 0; data outputs may hold stale values.
REQ-029 flush_i SHALL force out_valid_o = 0 on the next edge, with priority over accept, hold and bubble insertion.
REQ-030 When flush_i is asserted, we_rd_o and is_load_o SHALL be cleared along with out_valid_o, so that no hazard is raised the following cycle.
REQ-031 Widths SHALL be parameter-driven, with no truncation of XLEN data.
REQ-032 The block SHALL be correct for NFWD = 1.

Reset
REQ-033 While rst_i = 0, out_valid_o, we_rd_o and is_load_o SHALL be 0, and dat_a_o, dat_b_o, st_dat_o, pc_o and rd_o SHALL be 0, asynchronously.
REQ-034 Reset deassertion SHALL require no extra idle cycle: accept is possible on the first edge after rst_i = 1.
REQ-035 Reset asserted mid-hold SHALL drop the held instruction.

Verification
REQ-036 Add with rs1=5, rs2=6, rs1_d_i=10, rs2_d_i=20, sel 00/00, no forwarding -> next cycle out_valid_o=1, dat_a_o=10, dat_b_o=20.
REQ-037 fwd_valid_i=11, fwd_rd_i[0]=fwd_rd_i[1]=5, fwd_dat_i = 0xAA (channel 0) / 0xBB (channel 1), rs1=5 -> dat_a_o=0xAA; with rs1=0 -> dat_a_o=0.
REQ-038 Load rd=7 held in slot, next instruction has rs2=7 and use_rs2_i=1, out_ready_i=1 -> hazard_o=1, in_ready_o=0, bubble out (out_valid_o=0) next cycle, then accepted the cycle after.
REQ-039 out_ready_i=0 for 3 cycles with a valid slot -> outputs unchanged and in_ready_o=0 throughout; release -> new instruction accepted in the same cycle.
REQ-040 flush_i asserted together with in_valid_i=1 while the slot is valid -> out_valid_o=0 next cycle and the instruction is not delivered.
REQ-041 rst_i driven low asynchronously mid-cycle while out_valid_o=1 -> out_valid_o=0 immediately, with all data outputs 0.
